// File: rtl/identify_queue_if.sv
// rtl/identify_queue_if.sv - instruction-word intake and decoded-entry drain handshakes for identify_queue
interface identify_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          i_valid;
    logic [0:31]   i_word;
    logic          o_ready;
    logic          o_valid;
    logic          i_ready;
    logic [0:63]   o_instr;
    logic          o_prefixed;
    logic          o_illegal;
    logic          o_bu_en;
    logic          o_bu_i_form;
    logic          o_bu_b_form;
    logic          o_bu_cond_lr;
    logic          o_bu_cond_ctr;
    logic          o_bu_cond_tar;
    logic          o_ls_en;
    logic [CW-1:0] o_count;

    modport master (
        output i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_instr, o_prefixed, o_illegal, o_bu_en,
        input  o_bu_i_form, o_bu_b_form, o_bu_cond_lr, o_bu_cond_ctr, o_bu_cond_tar,
        input  o_ls_en, o_count
    );

    modport slave (
        input  i_valid, i_word, i_ready,
        output o_ready, o_valid, o_instr, o_prefixed, o_illegal, o_bu_en,
        output o_bu_i_form, o_bu_b_form, o_bu_cond_lr, o_bu_cond_ctr, o_bu_cond_tar,
        output o_ls_en, o_count
    );
endinterface

// File: rtl/identify_queue.sv
// rtl/identify_queue.sv - prefixed-instruction assembly, branch/load-store classification, DEPTH-entry decoded FIFO
// Optional load/store classification is built when IDENTIFY_LS_EN is defined.
module identify_queue #(
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    identify_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SUFFIX = 1'b1;

    localparam logic [0:5] OP_PREFIX = 6'd1;
    localparam logic [0:5] OP_B      = 6'd16;
    localparam logic [0:5] OP_I      = 6'd18;
    localparam logic [0:5] OP_XL     = 6'd19;
    localparam logic [0:9] XO_LR     = 10'd16;
    localparam logic [0:9] XO_CTR    = 10'd528;
    localparam logic [0:9] XO_TAR    = 10'd560;

    // Branch flag vector layout, MSB first: i_form, b_form, cond_lr, cond_ctr, cond_tar
    localparam int BR_I   = 4;
    localparam int BR_B   = 3;
    localparam int BR_LR  = 2;
    localparam int BR_CTR = 1;
    localparam int BR_TAR = 0;

    function automatic logic [4:0] branch_class(input logic [0:5] op, input logic [0:9] xo);
        logic [4:0] f;
        f = '0;
        case (op)
            OP_I:    f[BR_I] = 1'b1;
            OP_B:    f[BR_B] = 1'b1;
            OP_XL: begin
                case (xo)
                    XO_LR:   f[BR_LR]  = 1'b1;
                    XO_CTR:  f[BR_CTR] = 1'b1;
                    XO_TAR:  f[BR_TAR] = 1'b1;
                    default: f = '0;
                endcase
            end
            default: f = '0;
        endcase
        return f;
    endfunction

`ifdef IDENTIFY_LS_EN
    function automatic logic is_ls(input logic [0:5] op);
        return ((op >= 6'd32) && (op <= 6'd47)) || (op == 6'd58) || (op == 6'd62);
    endfunction
`endif

    logic [0:0]    state;
    logic [0:31]   prefix_q;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [0:5]    word_op;
    logic [0:9]    word_xo;

    logic [0:63]   new_instr;
    logic          new_prefixed;
    logic          new_illegal;
    logic [4:0]    new_br;

    logic [0:63]   mem_instr    [DEPTH];
    logic          mem_prefixed [DEPTH];
    logic          mem_illegal  [DEPTH];
    logic [4:0]    mem_br       [DEPTH];

    logic [4:0]    head_br;

    assign word_op = bus.i_word[0:5];
    assign word_xo = bus.i_word[21:30];

    // o_ready looks only at registered occupancy so a pop never frees a slot combinationally
    assign bus.o_ready = (count != FULL) & ~i_flush;
    assign accept      = bus.i_valid & bus.o_ready;
    assign push        = accept & ((state == ST_SUFFIX) | (word_op != OP_PREFIX));
    assign head_valid  = (count != '0);
    assign pop         = head_valid & bus.i_ready & ~i_flush;

    always_comb begin
        new_instr    = '0;
        new_prefixed = 1'b0;
        new_illegal  = 1'b0;
        new_br       = '0;
        if (state == ST_SUFFIX) begin
            new_instr    = {prefix_q, bus.i_word};
            new_prefixed = 1'b1;
            new_illegal  = (word_op == OP_PREFIX);
        end else begin
            new_instr    = {bus.i_word, 32'h0};
            new_br       = branch_class(word_op, word_xo);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            prefix_q <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (i_flush) begin
            state    <= ST_IDLE;
            prefix_q <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (accept) begin
                if (state == ST_IDLE) begin
                    if (word_op == OP_PREFIX) begin
                        state    <= ST_SUFFIX;
                        prefix_q <= bus.i_word;
                    end
                end else begin
                    state <= ST_IDLE;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; every head output is gated by head_valid
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_instr[wr_ptr]    <= new_instr;
            mem_prefixed[wr_ptr] <= new_prefixed;
            mem_illegal[wr_ptr]  <= new_illegal;
            mem_br[wr_ptr]       <= new_br;
        end
    end

    assign head_br           = head_valid ? mem_br[rd_ptr] : 5'b0;
    assign bus.o_valid       = head_valid;
    assign bus.o_instr       = head_valid ? mem_instr[rd_ptr] : 64'h0;
    assign bus.o_prefixed    = head_valid & mem_prefixed[rd_ptr];
    assign bus.o_illegal     = head_valid & mem_illegal[rd_ptr];
    assign bus.o_bu_en       = |head_br;
    assign bus.o_bu_i_form   = head_br[BR_I];
    assign bus.o_bu_b_form   = head_br[BR_B];
    assign bus.o_bu_cond_lr  = head_br[BR_LR];
    assign bus.o_bu_cond_ctr = head_br[BR_CTR];
    assign bus.o_bu_cond_tar = head_br[BR_TAR];
    assign bus.o_count       = count;

`ifdef IDENTIFY_LS_EN
    logic new_ls;
    logic mem_ls [DEPTH];

    // Illegal prefix/prefix pairs never classify as load/store
    always_comb begin
        new_ls = 1'b0;
        if (state == ST_SUFFIX) begin
            new_ls = (word_op != OP_PREFIX) & is_ls(word_op);
        end else begin
            new_ls = is_ls(word_op);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_ls[wr_ptr] <= new_ls;
        end
    end

    assign bus.o_ls_en = head_valid & mem_ls[rd_ptr];
`else
    assign bus.o_ls_en = 1'b0;
`endif

endmodule
